// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point multiplier datapath.
package fp_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  localparam int FLG_W    = 5;
  localparam int FLG_INV  = 4;
  localparam int FLG_OVF  = 3;
  localparam int FLG_UNF  = 2;
  localparam int FLG_NX   = 1;
  localparam int FLG_ZERO = 0;

  typedef struct packed {
    logic inv;
    logic inf;
    logic zero;
  } fp_cls_t;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final stage of the multiplier: rounding, carry renormalisation,
// overflow/underflow resolution and packing of specials.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                    sign_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic [MAN_W:0]          sig_i,
  input  logic                    guard_i,
  input  logic                    sticky_i,
  input  logic [1:0]              rm_i,
  input  logic                    inv_i,
  input  logic                    inf_i,
  input  logic                    zero_i,
  output logic [EXP_W+MAN_W:0]    result_o,
  output logic [FLG_W-1:0]        flags_o
);
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] EMAX  = EW2'(exp_max(EXP_W));
  localparam logic signed [EW2-1:0] EZERO = '0;

  function automatic logic round_inc(input logic [1:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    case (rm)
      RM_RNE:  return g & (s | lsb);
      RM_RTZ:  return 1'b0;
      RM_RDN:  return sign & (g | s);
      default: return ~sign & (g | s);
    endcase
  endfunction

  function automatic logic [EXP_W+MAN_W:0] sat_result(input logic [1:0] rm, input logic sign);
    logic to_inf;
    to_inf = (rm == RM_RNE) | ((rm == RM_RDN) & sign) | ((rm == RM_RUP) & ~sign);
    if (to_inf) return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    return {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  endfunction

  logic                  inc;
  logic                  carry;
  logic                  inexact;
  logic [MAN_W:0]        sig_r;
  logic signed [EW2-1:0] exp_r;

  // The significand always carries its hidden one here, so a wrap to a
  // cleared hidden bit is exactly the rounding carry-out.
  always_comb begin
    inexact  = guard_i | sticky_i;
    inc      = round_inc(rm_i, sign_i, sig_i[0], guard_i, sticky_i);
    sig_r    = sig_i + {{MAN_W{1'b0}}, inc};
    carry    = ~sig_r[MAN_W];
    exp_r    = exp_i + $signed({{(EW2-1){1'b0}}, carry});
    result_o = '0;
    flags_o  = '0;
    if (inv_i) begin
      result_o          = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_o[FLG_INV]  = 1'b1;
    end else if (inf_i) begin
      result_o          = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_i) begin
      result_o          = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_o[FLG_ZERO] = 1'b1;
    end else if (exp_i <= EZERO) begin
      result_o          = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_o[FLG_UNF]  = 1'b1;
      flags_o[FLG_NX]   = 1'b1;
      flags_o[FLG_ZERO] = 1'b1;
    end else if (exp_r >= EMAX) begin
      result_o          = sat_result(rm_i, sign_i);
      flags_o[FLG_OVF]  = 1'b1;
      flags_o[FLG_NX]   = 1'b1;
    end else begin
      result_o          = {sign_i, exp_r[EXP_W-1:0], sig_r[MAN_W-1:0]};
      flags_o[FLG_NX]   = inexact;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Four-stage pipelined IEEE-754 multiplier with valid/ready at both ends.
// One global advance signal moves every stage together; bubbles are kept.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [1:0]           rm,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [FLG_W-1:0]     flags,
  output logic [TAG_W-1:0]     out_tag
);
  localparam int SIG_W = MAN_W + 1;
  localparam int PRD_W = 2 * SIG_W;
  localparam int EW2   = EXP_W + 2;
  localparam logic signed [EW2-1:0] BIAS = EW2'(exp_bias(EXP_W));
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic adv;
  logic vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;

  assign adv      = ~vld_p4_q | out_ready;
  assign in_ready = adv;

  // S1: unpack and classify; subnormal inputs read as zero
  logic [EXP_W-1:0]      ea, eb;
  logic [MAN_W-1:0]      fa, fb;
  logic                  a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic                  inv_d, inf_d, zero_d;
  logic signed [EW2-1:0] exp_p1_d;

  always_comb begin
    ea       = a[EXP_W+MAN_W-1:MAN_W];
    eb       = b[EXP_W+MAN_W-1:MAN_W];
    fa       = a[MAN_W-1:0];
    fb       = b[MAN_W-1:0];
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    a_inf    = (ea == EXP_ONES) & (fa == '0);
    b_inf    = (eb == EXP_ONES) & (fb == '0);
    a_nan    = (ea == EXP_ONES) & (fa != '0);
    b_nan    = (eb == EXP_ONES) & (fb != '0);
    inv_d    = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    inf_d    = ~inv_d & (a_inf | b_inf);
    zero_d   = ~inv_d & ~inf_d & (a_zero | b_zero);
    exp_p1_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  end

  logic                  sign_p1_q;
  logic signed [EW2-1:0] exp_p1_q;
  logic [SIG_W-1:0]      siga_p1_q, sigb_p1_q;
  fp_cls_t               cls_p1_q;
  logic [1:0]            rm_p1_q;
  logic [TAG_W-1:0]      tag_p1_q;

  // S2: full significand product
  logic                  sign_p2_q;
  logic signed [EW2-1:0] exp_p2_q;
  logic [PRD_W-1:0]      prod_p2_q;
  fp_cls_t               cls_p2_q;
  logic [1:0]            rm_p2_q;
  logic [TAG_W-1:0]      tag_p2_q;

  // S3: one-bit normalise, form guard and sticky
  logic [SIG_W-1:0]      sig_p3_d;
  logic                  grd_p3_d, stk_p3_d;
  logic signed [EW2-1:0] exp_p3_d;

  always_comb begin
    if (prod_p2_q[PRD_W-1]) begin
      sig_p3_d = prod_p2_q[PRD_W-1 -: SIG_W];
      grd_p3_d = prod_p2_q[MAN_W];
      stk_p3_d = |prod_p2_q[MAN_W-1:0];
      exp_p3_d = exp_p2_q + EW2'(1);
    end else begin
      sig_p3_d = prod_p2_q[PRD_W-2 -: SIG_W];
      grd_p3_d = prod_p2_q[MAN_W-1];
      stk_p3_d = |prod_p2_q[MAN_W-2:0];
      exp_p3_d = exp_p2_q;
    end
  end

  logic                  sign_p3_q;
  logic signed [EW2-1:0] exp_p3_q;
  logic [SIG_W-1:0]      sig_p3_q;
  logic                  grd_p3_q, stk_p3_q;
  fp_cls_t               cls_p3_q;
  logic [1:0]            rm_p3_q;
  logic [TAG_W-1:0]      tag_p3_q;

  // S4: round and pack
  logic [EXP_W+MAN_W:0]  res_p4_d;
  logic [FLG_W-1:0]      flg_p4_d;

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign_i   (sign_p3_q),
    .exp_i    (exp_p3_q),
    .sig_i    (sig_p3_q),
    .guard_i  (grd_p3_q),
    .sticky_i (stk_p3_q),
    .rm_i     (rm_p3_q),
    .inv_i    (cls_p3_q.inv),
    .inf_i    (cls_p3_q.inf),
    .zero_i   (cls_p3_q.zero),
    .result_o (res_p4_d),
    .flags_o  (flg_p4_d)
  );

  logic [EXP_W+MAN_W:0]  res_p4_q;
  logic [FLG_W-1:0]      flg_p4_q;
  logic [TAG_W-1:0]      tag_p4_q;

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1_q <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
      exp_p1_q  <= exp_p1_d;
      siga_p1_q <= {1'b1, fa};
      sigb_p1_q <= {1'b1, fb};
      cls_p1_q  <= '{inv: inv_d, inf: inf_d, zero: zero_d};
      rm_p1_q   <= rm;
      tag_p1_q  <= in_tag;

      sign_p2_q <= sign_p1_q;
      exp_p2_q  <= exp_p1_q;
      prod_p2_q <= siga_p1_q * sigb_p1_q;
      cls_p2_q  <= cls_p1_q;
      rm_p2_q   <= rm_p1_q;
      tag_p2_q  <= tag_p1_q;

      sign_p3_q <= sign_p2_q;
      exp_p3_q  <= exp_p3_d;
      sig_p3_q  <= sig_p3_d;
      grd_p3_q  <= grd_p3_d;
      stk_p3_q  <= stk_p3_d;
      cls_p3_q  <= cls_p2_q;
      rm_p3_q   <= rm_p2_q;
      tag_p3_q  <= tag_p2_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
      res_p4_q <= '0;
      flg_p4_q <= '0;
      tag_p4_q <= '0;
    end else if (adv) begin
      vld_p1_q <= in_valid;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      vld_p4_q <= vld_p3_q;
      res_p4_q <= res_p4_d;
      flg_p4_q <= flg_p4_d;
      tag_p4_q <= tag_p3_q;
    end
  end

  assign out_valid = vld_p4_q;
  assign result    = res_p4_q;
  assign flags     = flg_p4_q;
  assign out_tag   = tag_p4_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: vector table plus streaming, backpressure,
// mid-flight reset and a binary16 instance.
module tb_fp_mult_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [1:0]  rm;
  logic [3:0]  in_tag, out_tag;
  logic [4:0]  flags;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_result;
  logic [1:0]  h_rm;
  logic [3:0]  h_tag, h_out_tag;
  logic [4:0]  h_flags;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   cyc     = 0;
  bit   stream_done;
  exp_t sb_q[$];
  vec_t vecs[21];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_mult_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rm(rm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .out_tag(out_tag)
  );

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_half (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .rm(h_rm), .in_tag(h_tag),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .flags(h_flags), .out_tag(h_out_tag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v, input logic [3:0] tag);
    int   n;
    exp_t e;
    n = 0;
    a = v.a; b = v.b; rm = v.rm; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    else begin
      e.res = v.res; e.flg = v.flg; e.tag = tag;
      sb_q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(sb_q.size()), 32'd0);
    sync();
  endtask

  task automatic latency_op(input vec_t v, input logic [3:0] tag, input string name);
    int c0, n;
    c0 = cyc;
    n  = 0;
    send(v, tag);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(cyc - c0), 32'd4);
    drain();
  endtask

  task automatic half_op(input logic [15:0] ha, input logic [15:0] hb, input logic [15:0] hres,
                         input logic [4:0] hflg, input logic [3:0] htag);
    int n;
    n = 0;
    h_a = ha; h_b = hb; h_rm = 2'b00; h_tag = htag; h_in_valid = 1'b1;
    @(negedge clk);
    check("half_in_ready", 32'(h_in_ready), 32'd1);
    @(posedge clk);
    #1;
    h_in_valid = 1'b0;
    while (!h_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("half_out_valid", 32'(h_out_valid), 32'd1);
    check("half_result", 32'(h_result), 32'(hres));
    check("half_flags", 32'(h_flags), 32'(hflg));
    check("half_tag", 32'(h_out_tag), 32'(htag));
    sync();
  endtask

  // Output monitor: scoreboard compare on transfer, stability while stalled.
  initial begin
    exp_t        e;
    bit          hold_vld;
    logic [31:0] hold_res;
    logic [4:0]  hold_flg;
    logic [3:0]  hold_tag;
    hold_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst || !out_valid) hold_vld = 1'b0;
      else begin
        if (hold_vld) begin
          check("hold_result", result, hold_res);
          check("hold_flags", 32'(flags), 32'(hold_flg));
          check("hold_tag", 32'(out_tag), 32'(hold_tag));
        end
        if (out_ready) begin
          hold_vld = 1'b0;
          if (sb_q.size() == 0) check("unexpected_output", 32'(out_valid), 32'd0);
          else begin
            e = sb_q.pop_front();
            check("result", result, e.res);
            check("flags", 32'(flags), 32'(e.flg));
            check("tag", 32'(out_tag), 32'(e.tag));
          end
        end else begin
          hold_vld = 1'b1;
          hold_res = result;
          hold_flg = flags;
          hold_tag = out_tag;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int acc0;
    vecs = '{
      '{32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 5'b00000},
      '{32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 5'b00010},
      '{32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 5'b00010},
      '{32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800002, 5'b00010},
      '{32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800003, 5'b00010},
      '{32'hBF800001, 32'h3F800001, 2'b10, 32'hBF800003, 5'b00010},
      '{32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000, 5'b01010},
      '{32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F7FFFFF, 5'b01010},
      '{32'h7F7FFFFF, 32'h40000000, 2'b10, 32'h7F7FFFFF, 5'b01010},
      '{32'h7F7FFFFF, 32'h40000000, 2'b11, 32'h7F800000, 5'b01010},
      '{32'hFF7FFFFF, 32'h40000000, 2'b10, 32'hFF800000, 5'b01010},
      '{32'hFF7FFFFF, 32'h40000000, 2'b11, 32'hFF7FFFFF, 5'b01010},
      '{32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 5'b10000},
      '{32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, 5'b00111},
      '{32'h80000000, 32'h3F800000, 2'b00, 32'h80000000, 5'b00001},
      '{32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 5'b10000},
      '{32'h7F800000, 32'hC0000000, 2'b00, 32'hFF800000, 5'b00000},
      '{32'h3F800001, 32'h3FC00000, 2'b00, 32'h3FC00002, 5'b00010},
      '{32'h3F800003, 32'h3FC00000, 2'b00, 32'h3FC00004, 5'b00010},
      '{32'h00000001, 32'h3F800000, 2'b00, 32'h00000000, 5'b00001},
      '{32'hBF800001, 32'h3F800001, 2'b11, 32'hBF800002, 5'b00010}
    };

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; rm = '0; in_tag = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0; h_rm = '0; h_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    check("reset_tag", 32'(out_tag), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_half_valid", 32'(h_out_valid), 32'd0);

    latency_op(vecs[0], 4'h5, "latency_basic");

    for (int i = 0; i < 21; i++) send(vecs[i], 4'(i));
    drain();

    // Stream of exact products (scale by +/-2) under backpressure.
    stream_done = 1'b0;
    out_ready   = 1'b0;
    acc0        = n_acc;
    fork
      begin
        vec_t v;
        for (int i = 0; i < 20; i++) begin
          v.a   = {1'b0, 8'(100 + i), 23'(i * 32'h1357)};
          v.b   = (i % 2 == 1) ? 32'hC0000000 : 32'h40000000;
          v.rm  = 2'(i % 4);
          v.res = {v.a[31] ^ v.b[31], v.a[30:23] + 8'd1, v.a[22:0]};
          v.flg = 5'b00000;
          send(v, 4'(i));
        end
        stream_done = 1'b1;
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        check("blocked_accepts_le4", 32'((n_acc - acc0) <= 4), 32'd1);
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("stream_accepts", 32'(n_acc - acc0), 32'd20);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) send(vecs[1], 4'(i + 1));
    sb_q.delete();
    rst = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_result", result, 32'd0);
    check("midreset_flags", 32'(flags), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_reset_idle", 32'(out_valid), 32'd0);
    latency_op(vecs[17], 4'hA, "latency_after_reset");

    half_op(16'h3E00, 16'h4000, 16'h4200, 5'b00000, 4'h3);
    half_op(16'h7BFF, 16'h4000, 16'h7C00, 5'b01010, 4'hC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
Parametrised, fully pipelined IEEE-754 binary floating-point multiplier with valid/ready handshakes at both ends.
- Generalises the fixed single-precision multiplier: configurable exponent/mantissa width, four runtime-selectable rounding modes, per-operation tag passthrough, and backpressure support.
- Sits between the operand issue logic and the result writeback/FIFO in the FP datapath.
- One result per cycle when not stalled.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width (significand = MAN_W+1 bits with hidden one)
TAG_W, 4, width of opaque tag carried alongside each operation

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept this cycle
a  in  EXP_W+MAN_W+1  operand A {sign, exp, frac}
b  in  EXP_W+MAN_W+1  operand B
rm  in  2  rounding mode, sampled with operands: 00 RNE, 01 RTZ, 10 RDN, 11 RUP
in_tag  in  TAG_W  user tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  EXP_W+MAN_W+1  product
flags  out  5  [4] invalid, [3] overflow, [2] underflow, [1] inexact, [0] zero result
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: asynchronous on rst low. All stage valid bits clear, so out_valid=0. result, flags and out_tag reset to 0. in_ready=1 after reset releases. In-flight operations are discarded; none are emitted after reset.
- Pipeline: 4 register stages. Latency is 4 cycles from accept (in_valid & in_ready) to out_valid, absent stall.
  - S1 unpack/classify: zero, subnormal, inf, NaN. Sign = Sa^Sb. Exponent sum is EXP_W+2 bits signed, minus bias.
  - S2 significand product: 2*(MAN_W+1) bits.
  - S3 normalise: 1-bit shift if product MSB set, exponent +1. Form guard and sticky (round bit and OR of remaining low bits).
  - S4 round per rm, post-round renormalise (carry out -> exponent +1), overflow/underflow resolution, pack.
- Handshake: global stall, adv = !v4 | out_ready. in_ready = adv.
  - On stall all stages hold; bubbles are not compressed.
  - out_valid/result/flags/out_tag stay stable while out_valid & !out_ready.
  - Order is strictly preserved.
- Subnormals: inputs treated as zero (DAZ). Tiny results flush to signed zero (FTZ) with underflow=1, inexact=1, zero=1.
- Specials:
  - NaN operand or inf*0: result is canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0), invalid=1.
  - inf*finite-nonzero: signed inf, no flags.
  - zero*finite: signed zero, zero=1.
- Rounding: RNE rounds to nearest, ties to even. RTZ truncates. RDN rounds up in magnitude if negative and inexact. RUP rounds up in magnitude if positive and inexact. inexact = guard|sticky (or overflow/underflow).
- Overflow (biased exp >= all-ones after rounding): overflow=1, inexact=1.
  - RNE: signed inf.
  - RTZ: signed max finite.
  - RDN: +max finite / -inf.
  - RUP: +inf / -max finite.
- No all-ones result override; NaN encoding is the only special pattern.
- Simultaneous accept and emit in the same cycle is allowed (full throughput).

Decomposition:
- Package fp_pkg: rounding-mode constants (RM_RNE/RTZ/RDN/RUP), flag bit index constants, and a function computing bias/max-exponent from EXP_W.
- One sub-module, fp_round_pack: combinational S4 logic taking sign, exponent, significand, guard, sticky, rm and class bits; returns packed result and flags.
- Top holds pipeline registers and handshake.

Test Plan:
- Basic (default params, RNE): a=0x3FC00000, b=0x40000000 -> result 0x40400000, flags 5'b00000, out_valid exactly 4 cycles after accept, tag echoed.
- Rounding: a=b=0x3F800001 under each mode -> RNE 0x3F800002, RTZ 0x3F800002, RDN 0x3F800002, RUP 0x3F800003; all flags 5'b00010. Negate a with RDN -> 0xBF800003.
- Overflow: a=0x7F7FFFFF, b=0x40000000 -> RNE 0x7F800000 flags 5'b01010; RTZ 0x7F7FFFFF flags 5'b01010.
- Specials/underflow:
  - inf*0 (0x7F800000, 0x00000000) -> 0x7FC00000 flags 5'b10000.
  - 0x00800000*0x3F000000 -> 0x00000000 flags 5'b00111.
  - 0x80000000*0x3F800000 -> 0x80000000 flags 5'b00001.
- Backpressure: stream 20 distinct ops with in_valid=1, out_ready low for 10 cycles then random -> at most 4 accepted while blocked, outputs held stable, all 20 results emitted in order with correct tags.
- Reset mid-operation: 3 ops in flight, drive rst low 1 cycle -> out_valid=0 immediately, no stale results after release, next op completes correctly in 4 cycles.
- Width generality: EXP_W=5, MAN_W=10 (binary16): 0x3E00*0x4000 -> 0x4200, 0x7BFF*0x4000 RNE -> 0x7C00 flags 5'b01010.
